sprite_compositor: RTL and testbench

Pipelined, parametrised pixel compositor between the VGA controller and the DAC. It draws NUM_SPRITES animated 1-bit sprites with per-sprite colour over the 1-bit maze bitmap. It returns registered RGB with a fixed latency. It also keeps sticky per-frame collision flags: sprite vs maze, and sprite 0 vs every other sprite.

---
 rtl/sprite_compositor.sv | 149 ++++++++++++++
 tb/tb_sprite_compositor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: per-sprite hit test (S1), ROM row fetch (S2),
// priority mux and sticky collision flags (S3).
module sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPRITE_SIZE = 32,
    parameter int          FRAME_BITS  = 2,
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter logic [23:0] MAP_COLOR   = 24'h0000FF,
    parameter logic [23:0] BG_COLOR    = 24'h000000,
    localparam int         SW          = $clog2(SPRITE_SIZE),
    localparam int         AW          = FRAME_BITS + SW
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    input  logic [9:0]                        DrawX,
    input  logic [9:0]                        DrawY,
    input  logic                              PixelValid,
    input  logic                              FrameStart,
    input  logic [NUM_SPRITES-1:0]            SpriteEnable,
    input  logic [NUM_SPRITES*10-1:0]         SpriteX,
    input  logic [NUM_SPRITES*10-1:0]         SpriteY,
    input  logic [NUM_SPRITES*FRAME_BITS-1:0] SpriteFrame,
    input  logic [NUM_SPRITES*24-1:0]         SpriteColor,
    output logic [NUM_SPRITES*AW-1:0]         SpriteRomAddr,
    input  logic [NUM_SPRITES*SPRITE_SIZE-1:0] SpriteRomData,
    output logic [9:0]                        MapRomAddr,
    input  logic [H_RES-1:0]                  MapRomData,
    output logic [7:0]                        Red,
    output logic [7:0]                        Green,
    output logic [7:0]                        Blue,
    output logic                              OutValid,
    output logic [NUM_SPRITES-1:0]            CollisionMap,
    output logic [NUM_SPRITES-1:0]            CollisionPlayer
);

    localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);
    localparam logic [10:0] HRES11 = 11'(H_RES);
    localparam logic [10:0] VRES11 = 11'(V_RES);

    logic [NUM_SPRITES-1:0]    hit_d;
    logic [NUM_SPRITES*SW-1:0] col_d;
    logic [NUM_SPRITES*AW-1:0] addr_d;
    logic                      in_range_d;

    logic                      s1_valid_q, s1_inr_q;
    logic [9:0]                s1_x_q;
    logic [NUM_SPRITES-1:0]    s1_hit_q;
    logic [NUM_SPRITES*SW-1:0] s1_col_q;
    logic [NUM_SPRITES*24-1:0] s1_color_q;

    logic                      s2_valid_q, s2_inr_q;
    logic [9:0]                s2_x_q;
    logic [NUM_SPRITES-1:0]    s2_hit_q;
    logic [NUM_SPRITES*SW-1:0] s2_col_q;
    logic [NUM_SPRITES*24-1:0] s2_color_q;

    logic [NUM_SPRITES-1:0]    opaque;
    logic                      maze_bit, pix_ok;
    logic [23:0]               color, rgb_d, rgb_q;
    logic                      found;
    logic [NUM_SPRITES-1:0]    map_set, ply_set;
    logic [NUM_SPRITES-1:0]    coll_map_d, coll_map_q, coll_ply_d, coll_ply_q;

    assign in_range_d = ({1'b0, DrawX} < HRES11) && ({1'b0, DrawY} < VRES11);

    // 11-bit differences: a pixel left of/above the sprite never aliases into it
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
        logic [10:0]            dx, dy;
        logic [SPRITE_SIZE-1:0] row;
        assign dx = {1'b0, DrawX} - {1'b0, SpriteX[10*g +: 10]};
        assign dy = {1'b0, DrawY} - {1'b0, SpriteY[10*g +: 10]};
        assign hit_d[g] = SpriteEnable[g]
                          && (DrawX >= SpriteX[10*g +: 10]) && (dx < SIZE11)
                          && (DrawY >= SpriteY[10*g +: 10]) && (dy < SIZE11);
        assign col_d[SW*g +: SW]  = dx[SW-1:0];
        assign addr_d[AW*g +: AW] = {SpriteFrame[FRAME_BITS*g +: FRAME_BITS], dy[SW-1:0]};
        assign row       = SpriteRomData[SPRITE_SIZE*g +: SPRITE_SIZE];
        assign opaque[g] = s2_hit_q[g] & row[s2_col_q[SW*g +: SW]];
    end

    always_comb begin
        pix_ok   = s2_valid_q & s2_inr_q;
        maze_bit = MapRomData[s2_x_q];
        color    = maze_bit ? MAP_COLOR : BG_COLOR;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (!found && opaque[i]) begin
                color = s2_color_q[24*i +: 24];
                found = 1'b1;
            end
        end
        rgb_d   = pix_ok ? color : '0;
        map_set = pix_ok ? (opaque & {NUM_SPRITES{maze_bit}}) : '0;
        ply_set = (pix_ok && opaque[0]) ? opaque : '0;
        ply_set[0] = 1'b0;
        coll_map_d = (FrameStart ? '0 : coll_map_q) | map_set;
        coll_ply_d = (FrameStart ? '0 : coll_ply_q) | ply_set;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_inr_q      <= 1'b0;
            s1_x_q        <= '0;
            s1_hit_q      <= '0;
            s1_col_q      <= '0;
            s1_color_q    <= '0;
            SpriteRomAddr <= '0;
            MapRomAddr    <= '0;
            s2_valid_q    <= 1'b0;
            s2_inr_q      <= 1'b0;
            s2_x_q        <= '0;
            s2_hit_q      <= '0;
            s2_col_q      <= '0;
            s2_color_q    <= '0;
            rgb_q         <= '0;
            OutValid      <= 1'b0;
            coll_map_q    <= '0;
            coll_ply_q    <= '0;
        end else begin
            s1_valid_q    <= PixelValid;
            s1_inr_q      <= in_range_d;
            s1_x_q        <= DrawX;
            s1_hit_q      <= hit_d;
            s1_col_q      <= col_d;
            s1_color_q    <= SpriteColor;
            SpriteRomAddr <= addr_d;
            MapRomAddr    <= DrawY;
            s2_valid_q    <= s1_valid_q;
            s2_inr_q      <= s1_inr_q;
            s2_x_q        <= s1_x_q;
            s2_hit_q      <= s1_hit_q;
            s2_col_q      <= s1_col_q;
            s2_color_q    <= s1_color_q;
            rgb_q         <= rgb_d;
            OutValid      <= s2_valid_q;
            coll_map_q    <= coll_map_d;
            coll_ply_q    <= coll_ply_d;
        end
    end

    assign Red             = rgb_q[23:16];
    assign Green           = rgb_q[15:8];
    assign Blue            = rgb_q[7:0];
    assign CollisionMap    = coll_map_q;
    assign CollisionPlayer = coll_ply_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: vector table plus hand sequences, with a
// fixed-latency scoreboard and registered ROM models.
module tb_sprite_compositor;

    localparam int NS = 4;
    localparam int SS = 32;
    localparam int FB = 2;
    localparam int AW = 7;
    localparam int HR = 640;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic [9:0]       DrawX = '0, DrawY = '0;
    logic             PixelValid = 1'b0, FrameStart = 1'b0;
    logic [NS-1:0]    SpriteEnable = '0;
    logic [NS*10-1:0] SpriteX = '0, SpriteY = '0;
    logic [NS*FB-1:0] SpriteFrame = '0;
    logic [NS*24-1:0] SpriteColor = '0;
    logic [NS*AW-1:0] SpriteRomAddr;
    logic [NS*SS-1:0] SpriteRomData;
    logic [9:0]       MapRomAddr;
    logic [HR-1:0]    MapRomData;
    logic [7:0]       Red, Green, Blue;
    logic             OutValid;
    logic [NS-1:0]    CollisionMap, CollisionPlayer;

    sprite_compositor #(
        .NUM_SPRITES(NS), .SPRITE_SIZE(SS), .FRAME_BITS(FB), .H_RES(HR),
        .V_RES(480), .MAP_COLOR(24'h0000FF), .BG_COLOR(24'h000000)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .PixelValid(PixelValid), .FrameStart(FrameStart),
        .SpriteEnable(SpriteEnable), .SpriteX(SpriteX), .SpriteY(SpriteY),
        .SpriteFrame(SpriteFrame), .SpriteColor(SpriteColor),
        .SpriteRomAddr(SpriteRomAddr), .SpriteRomData(SpriteRomData),
        .MapRomAddr(MapRomAddr), .MapRomData(MapRomData),
        .Red(Red), .Green(Green), .Blue(Blue), .OutValid(OutValid),
        .CollisionMap(CollisionMap), .CollisionPlayer(CollisionPlayer)
    );

    always #5 Clk = ~Clk;

    logic [SS-1:0] spr_rom [NS][128];
    logic [HR-1:0] map_rom [1024];

    always @(posedge Clk) begin
        for (int i = 0; i < NS; i++)
            SpriteRomData[i*SS +: SS] <= spr_rom[i][SpriteRomAddr[i*AW +: AW]];
        MapRomData <= map_rom[MapRomAddr];
    end

    typedef struct {
        string       name;
        logic [23:0] rgb;
        logic        ov;
    } exp_t;

    typedef struct {
        string       name;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        v;
        logic [23:0] rgb;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [9:0] x, input logic [9:0] y,
                                input logic v, input logic [23:0] rgb);
        vec_t r;
        r.name = n; r.x = x; r.y = y; r.v = v; r.rgb = rgb;
        return r;
    endfunction

    // Each call is one pixel clock; the pixel driven three calls ago is now at the outputs.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic v,
                        input logic [23:0] rgb, input string name);
        exp_t e;
        @(negedge Clk);
        if (sb.size() == 3) begin
            e = sb.pop_front();
            chk({e.name, "_rgb"}, {8'h0, Red, Green, Blue}, {8'h0, e.rgb});
            chk({e.name, "_ov"}, {31'h0, OutValid}, {31'h0, e.ov});
        end
        DrawX = x; DrawY = y; PixelValid = v;
        e.name = name; e.rgb = rgb; e.ov = v;
        sb.push_back(e);
    endtask

    task automatic flush();
        repeat (3) step(10'd0, 10'd0, 1'b0, 24'h000000, "idle");
    endtask

    task automatic pulse_fs();
        FrameStart = 1'b1;
        step(10'd0, 10'd0, 1'b0, 24'h000000, "idle_fs");
        FrameStart = 1'b0;
    endtask

    task automatic set_sprite(input int i, input logic [9:0] x, input logic [9:0] y,
                              input logic [1:0] fr, input logic [23:0] col);
        SpriteX[i*10 +: 10]  = x;
        SpriteY[i*10 +: 10]  = y;
        SpriteFrame[i*FB +: FB] = fr;
        SpriteColor[i*24 +: 24] = col;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < NS; s++)
            for (int r = 0; r < 128; r++) spr_rom[s][r] = '0;
        for (int r = 0; r < 1024; r++) map_rom[r] = '0;
        spr_rom[0][33] = 32'h8000_0001;
        for (int r = 64; r < 96; r++) spr_rom[0][r] = '1;
        for (int r = 0; r < 32; r++) begin
            spr_rom[1][r] = '1;
            spr_rom[2][r] = '1;
            spr_rom[3][r] = '1;
        end
        map_rom[40][300] = 1'b1;
        map_rom[480][5]  = 1'b1;

        #12;
        chk("rst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        chk("rst_ov", {31'h0, OutValid}, 32'h0);
        chk("rst_cmap", {28'h0, CollisionMap}, 32'h0);
        chk("rst_cply", {28'h0, CollisionPlayer}, 32'h0);
        chk("rst_saddr", {4'h0, SpriteRomAddr}, 32'h0);
        chk("rst_maddr", {22'h0, MapRomAddr}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Table phase: sprite 0 at (100,100) frame 1, sprite 1 clipped at X=620
        set_sprite(0, 10'd100, 10'd100, 2'd1, 24'hFFFF00);
        set_sprite(1, 10'd620, 10'd200, 2'd0, 24'hFF0000);
        SpriteEnable = 4'b0011;
        tbl.push_back(mk("s0_col0",    10'd100, 10'd101, 1'b1, 24'hFFFF00));
        tbl.push_back(mk("s0_col1",    10'd101, 10'd101, 1'b1, 24'h000000));
        tbl.push_back(mk("s0_col31",   10'd131, 10'd101, 1'b1, 24'hFFFF00));
        tbl.push_back(mk("s0_xpast",   10'd132, 10'd101, 1'b1, 24'h000000));
        tbl.push_back(mk("s0_xbefore", 10'd99,  10'd101, 1'b1, 24'h000000));
        tbl.push_back(mk("s0_invalid", 10'd100, 10'd101, 1'b0, 24'h000000));
        tbl.push_back(mk("s1_left",    10'd620, 10'd210, 1'b1, 24'hFF0000));
        tbl.push_back(mk("s1_right",   10'd639, 10'd210, 1'b1, 24'hFF0000));
        tbl.push_back(mk("s1_nowrap",  10'd0,   10'd210, 1'b1, 24'h000000));
        tbl.push_back(mk("s1_col619",  10'd619, 10'd210, 1'b1, 24'h000000));
        tbl.push_back(mk("s1_y31",     10'd620, 10'd231, 1'b1, 24'hFF0000));
        tbl.push_back(mk("s1_y32",     10'd620, 10'd232, 1'b1, 24'h000000));
        tbl.push_back(mk("s1_yabove",  10'd620, 10'd199, 1'b1, 24'h000000));
        tbl.push_back(mk("maze_hit",   10'd300, 10'd40,  1'b1, 24'h0000FF));
        tbl.push_back(mk("maze_miss",  10'd301, 10'd40,  1'b1, 24'h000000));
        tbl.push_back(mk("x640",       10'd640, 10'd10,  1'b1, 24'h000000));
        tbl.push_back(mk("x640_spr",   10'd640, 10'd210, 1'b1, 24'h000000));
        tbl.push_back(mk("y480_maze",  10'd5,   10'd480, 1'b1, 24'h000000));
        foreach (tbl[k]) step(tbl[k].x, tbl[k].y, tbl[k].v, tbl[k].rgb, tbl[k].name);
        flush();

        // Priority: sprite 0 beats sprite 1; enable change affects later pixels only
        set_sprite(0, 10'd200, 10'd50, 2'd2, 24'hFFFF00);
        set_sprite(1, 10'd200, 10'd50, 2'd0, 24'hFF0000);
        SpriteEnable = 4'b0011;
        step(10'd210, 10'd60, 1'b1, 24'hFFFF00, "prio_s0");
        step(10'd0, 10'd0, 1'b0, 24'h000000, "idle");
        SpriteEnable = 4'b0010;
        step(10'd210, 10'd60, 1'b1, 24'hFF0000, "prio_s1");
        flush();

        // Sprite vs maze collision, clear, and clear-vs-set on the same edge
        set_sprite(2, 10'd290, 10'd30, 2'd0, 24'h00FF00);
        SpriteEnable = 4'b0100;
        pulse_fs();
        chk("cmap_clear0", {28'h0, CollisionMap}, 32'h0);
        step(10'd300, 10'd40, 1'b1, 24'h00FF00, "s2_on_maze");
        flush();
        chk("cmap_set", {28'h0, CollisionMap}, 32'h4);
        chk("cply_none", {28'h0, CollisionPlayer}, 32'h0);
        pulse_fs();
        chk("cmap_fs", {28'h0, CollisionMap}, 32'h0);
        step(10'd300, 10'd40, 1'b1, 24'h00FF00, "s2_on_maze2");
        step(10'd0, 10'd0, 1'b0, 24'h000000, "idle");
        step(10'd0, 10'd0, 1'b0, 24'h000000, "idle");
        FrameStart = 1'b1;
        step(10'd0, 10'd0, 1'b0, 24'h000000, "idle");
        FrameStart = 1'b0;
        chk("cmap_setwins", {28'h0, CollisionMap}, 32'h4);
        flush();

        // Player vs sprite 3, then sprite 1 vs sprite 3 without the player
        set_sprite(0, 10'd400, 10'd300, 2'd2, 24'hFFFF00);
        set_sprite(3, 10'd410, 10'd300, 2'd0, 24'h00FFFF);
        SpriteEnable = 4'b1001;
        pulse_fs();
        step(10'd415, 10'd310, 1'b1, 24'hFFFF00, "s0_over_s3");
        flush();
        chk("cply_s3", {28'h0, CollisionPlayer}, 32'h8);
        chk("cmap_none", {28'h0, CollisionMap}, 32'h0);
        set_sprite(1, 10'd400, 10'd300, 2'd0, 24'hFF0000);
        SpriteEnable = 4'b1010;
        pulse_fs();
        step(10'd415, 10'd310, 1'b1, 24'hFF0000, "s1_over_s3");
        flush();
        chk("cply_noplayer", {28'h0, CollisionPlayer}, 32'h0);

        // Mid-line reset drops in-flight pixels
        SpriteEnable = 4'b1001;
        repeat (3) step(10'd415, 10'd310, 1'b1, 24'hFFFF00, "pre_rst");
        Reset_n = 1'b0;
        PixelValid = 1'b0;
        #1;
        chk("midrst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        chk("midrst_ov", {31'h0, OutValid}, 32'h0);
        chk("midrst_cply", {28'h0, CollisionPlayer}, 32'h0);
        chk("midrst_cmap", {28'h0, CollisionMap}, 32'h0);
        sb.delete();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        step(10'd0, 10'd0, 1'b0, 24'h000000, "post_rst_idle");
        step(10'd0, 10'd0, 1'b0, 24'h000000, "post_rst_idle");
        step(10'd415, 10'd310, 1'b1, 24'hFFFF00, "post_rst_px");
        flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
